// File: rtl/tlb_ctrl_pkg.sv
// Shared definitions for the TLB controller: CP0 TLB op codes, FSM state encoding
// and default geometry.
package tlb_ctrl_pkg;

    localparam int N_ENTRY_DEF = 16;
    localparam int IDX_W_DEF   = 4;

    localparam logic [1:0] OP_TLBP  = 2'd0;
    localparam logic [1:0] OP_TLBR  = 2'd1;
    localparam logic [1:0] OP_TLBWI = 2'd2;
    localparam logic [1:0] OP_TLBWR = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_XLATE = 3'd1,
        S_PROBE = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } tlb_state_e;

endpackage

// File: rtl/tlb_random.sv
// CP0 Random register: free-running down-counter that wraps to the top entry
// once it reaches the Wired boundary, so wired entries are never replaced.
module tlb_random
    import tlb_ctrl_pkg::*;
#(
    parameter int N_ENTRY = N_ENTRY_DEF,
    parameter int IDX_W   = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] wired,
    input  logic             wired_we,
    output logic [IDX_W-1:0] random
);

    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(N_ENTRY - 1);

    logic [IDX_W-1:0] random_r;
    logic [IDX_W-1:0] random_nx_s;

    // Next Random value with Wired wrap and forced reload on Wired write
    always_comb begin
        random_nx_s = MAX_IDX;
        if (wired_we) begin
            random_nx_s = MAX_IDX;
        end else if (wired >= MAX_IDX) begin
            random_nx_s = MAX_IDX;
        end else if (random_r <= wired) begin
            random_nx_s = MAX_IDX;
        end else begin
            random_nx_s = random_r - IDX_W'(1);
        end
    end

    // Random register
    always_ff @(posedge clk) begin
        if (rst) begin
            random_r <= MAX_IDX;
        end else begin
            random_r <= random_nx_s;
        end
    end

    assign random = random_r;

endmodule

// File: rtl/tlb_ctrl.sv
// TLB controller: arbitrates fetch/data translation requests and CP0 TLB
// maintenance ops onto a single TLB lookup/write port.
module tlb_ctrl
    import tlb_ctrl_pkg::*;
#(
    parameter int N_ENTRY = N_ENTRY_DEF,
    parameter int IDX_W   = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [31:0]      if_vaddr,
    input  logic             mem_req,
    input  logic [31:0]      mem_vaddr,
    output logic             if_gnt,
    output logic             mem_gnt,
    output logic             if_rvalid,
    output logic             mem_rvalid,
    output logic [31:0]      if_paddr,
    output logic [31:0]      mem_paddr,
    output logic             if_miss,
    output logic             mem_miss,
    input  logic             op_valid,
    input  logic [1:0]       op_code,
    output logic             op_busy,
    output logic             op_done,
    input  logic [31:0]      cp0_index,
    input  logic [31:0]      cp0_entry_hi,
    input  logic [IDX_W-1:0] wired,
    input  logic             wired_we,
    output logic [31:0]      probe_result,
    output logic             probe_we,
    output logic             read_we,
    output logic [31:0]      tlb_vaddr,
    input  logic [31:0]      tlb_paddr,
    input  logic             tlb_hit,
    output logic             tlb_we,
    output logic             tlb_rd,
    output logic [31:0]      tlb_index,
    input  logic [31:0]      tlb_index_out,
    output logic [IDX_W-1:0] random
);

    tlb_state_e       state_r;
    tlb_state_e       state_nx_s;
    logic [31:0]      vaddr_r;
    logic             src_mem_r;
    logic [IDX_W-1:0] wr_idx_r;
    logic [31:0]      paddr_r;
    logic             miss_r;
    logic             if_rvalid_r;
    logic             mem_rvalid_r;
    logic [IDX_W-1:0] random_s;

    logic             if_gnt_s, mem_gnt_s, op_busy_s, op_done_s;
    logic             probe_we_s, read_we_s, tlb_we_s, tlb_rd_s;
    logic [31:0]      tlb_vaddr_s, tlb_index_s, probe_result_s;
    logic [IDX_W-1:0] probe_idx_s;
    logic             unused_s;

    assign unused_s = ^{cp0_index[31:IDX_W], tlb_index_out[31:IDX_W]};

    tlb_random #(
        .N_ENTRY (N_ENTRY),
        .IDX_W   (IDX_W)
    ) u_random (
        .clk      (clk),
        .rst      (rst),
        .wired    (wired),
        .wired_we (wired_we),
        .random   (random_s)
    );

    // A probe miss reports index zero alongside the P bit
    assign probe_idx_s = tlb_hit ? tlb_index_out[IDX_W-1:0] : {IDX_W{1'b0}};

    // Next-state and per-state strobes; everything is held low while rst is high
    always_comb begin
        state_nx_s     = state_r;
        if_gnt_s       = 1'b0;
        mem_gnt_s      = 1'b0;
        op_busy_s      = 1'b0;
        op_done_s      = 1'b0;
        probe_we_s     = 1'b0;
        read_we_s      = 1'b0;
        tlb_we_s       = 1'b0;
        tlb_rd_s       = 1'b0;
        tlb_vaddr_s    = 32'h0;
        tlb_index_s    = 32'h0;
        probe_result_s = 32'h0;
        if (rst) begin
            state_nx_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (op_valid) begin
                        op_busy_s = 1'b1;
                        case (op_code)
                            OP_TLBP: state_nx_s = S_PROBE;
                            OP_TLBR: state_nx_s = S_READ;
                            default: state_nx_s = S_WRITE;
                        endcase
                    end else if (mem_req) begin
                        mem_gnt_s  = 1'b1;
                        state_nx_s = S_XLATE;
                    end else if (if_req) begin
                        if_gnt_s   = 1'b1;
                        state_nx_s = S_XLATE;
                    end else begin
                        state_nx_s = S_IDLE;
                    end
                end
                S_XLATE: begin
                    tlb_vaddr_s = vaddr_r;
                    state_nx_s  = S_IDLE;
                end
                S_PROBE: begin
                    op_busy_s      = 1'b1;
                    tlb_vaddr_s    = cp0_entry_hi;
                    probe_we_s     = 1'b1;
                    probe_result_s = {~tlb_hit, {(31-IDX_W){1'b0}}, probe_idx_s};
                    state_nx_s     = S_DONE;
                end
                S_READ: begin
                    op_busy_s   = 1'b1;
                    tlb_rd_s    = 1'b1;
                    read_we_s   = 1'b1;
                    tlb_index_s = {{(32-IDX_W){1'b0}}, cp0_index[IDX_W-1:0]};
                    state_nx_s  = S_DONE;
                end
                S_WRITE: begin
                    op_busy_s   = 1'b1;
                    tlb_we_s    = 1'b1;
                    tlb_index_s = {{(32-IDX_W){1'b0}}, wr_idx_r};
                    state_nx_s  = S_DONE;
                end
                S_DONE: begin
                    op_busy_s  = 1'b1;
                    op_done_s  = 1'b1;
                    state_nx_s = S_IDLE;
                end
                default: begin
                    state_nx_s = S_IDLE;
                end
            endcase
        end
    end

    // State, request latch, write index capture and registered translation result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            vaddr_r      <= 32'h0;
            src_mem_r    <= 1'b0;
            wr_idx_r     <= {IDX_W{1'b0}};
            paddr_r      <= 32'h0;
            miss_r       <= 1'b0;
            if_rvalid_r  <= 1'b0;
            mem_rvalid_r <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            if_rvalid_r  <= 1'b0;
            mem_rvalid_r <= 1'b0;
            if (mem_gnt_s || if_gnt_s) begin
                vaddr_r   <= mem_gnt_s ? mem_vaddr : if_vaddr;
                src_mem_r <= mem_gnt_s;
            end
            // Random is captured before any same-cycle Wired write reloads it
            if ((state_r == S_IDLE) && op_valid) begin
                wr_idx_r <= (op_code == OP_TLBWR) ? random_s : cp0_index[IDX_W-1:0];
            end
            if (state_r == S_XLATE) begin
                paddr_r      <= tlb_paddr;
                miss_r       <= ~tlb_hit;
                if_rvalid_r  <= ~src_mem_r;
                mem_rvalid_r <= src_mem_r;
            end
        end
    end

    assign if_gnt       = if_gnt_s;
    assign mem_gnt      = mem_gnt_s;
    assign if_rvalid    = if_rvalid_r;
    assign mem_rvalid   = mem_rvalid_r;
    assign if_paddr     = paddr_r;
    assign mem_paddr    = paddr_r;
    assign if_miss      = miss_r;
    assign mem_miss     = miss_r;
    assign op_busy      = op_busy_s;
    assign op_done      = op_done_s;
    assign probe_result = probe_result_s;
    assign probe_we     = probe_we_s;
    assign read_we      = read_we_s;
    assign tlb_vaddr    = tlb_vaddr_s;
    assign tlb_we       = tlb_we_s;
    assign tlb_rd       = tlb_rd_s;
    assign tlb_index    = tlb_index_s;
    assign random       = random_s;

endmodule
